// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/bubble sequencer.
// Register-address width, SRAM wait-FSM state encodings and the operand match helper.
package pipeline_stall_ctrl_pkg;

  localparam int REG_ADDRESS_LEN = 4;

  typedef enum logic [1:0] {
    SRAM_IDLE = 2'd0,
    SRAM_WAIT = 2'd1,
    SRAM_DONE = 2'd2
  } sram_state_t;

  // True when an ID source reads the given destination; src2 only counts when it is live.
  function automatic logic reg_match(
    input logic [REG_ADDRESS_LEN-1:0] src1,
    input logic [REG_ADDRESS_LEN-1:0] src2,
    input logic                       src2_live,
    input logic [REG_ADDRESS_LEN-1:0] dst
  );
    return (src1 == dst) || (src2_live && (src2 == dst));
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_hazard_detect.sv
// Combinational data-hazard detector for the ID stage against EXE and MEM destinations.
// With forwarding only the load-use case stalls; otherwise any pending write-back does.
module hazard_detect
  import pipeline_stall_ctrl_pkg::*;
(
  input  logic                       en_forwarding,
  input  logic                       ignore_hazard,
  input  logic [REG_ADDRESS_LEN-1:0] ID_src1,
  input  logic [REG_ADDRESS_LEN-1:0] ID_src2,
  input  logic                       ID_two_src,
  input  logic [REG_ADDRESS_LEN-1:0] EXE_dst,
  input  logic                       EXE_wb_en,
  input  logic                       EXE_mem_read,
  input  logic [REG_ADDRESS_LEN-1:0] MEM_dst,
  input  logic                       MEM_wb_en,
  output logic                       hz
);

  logic exe_match;
  logic mem_match;
  logic raw_hz;
  logic can_ignore;

  assign exe_match = reg_match(ID_src1, ID_src2, ID_two_src, EXE_dst);
  assign mem_match = reg_match(ID_src1, ID_src2, ID_two_src, MEM_dst);

  assign raw_hz = en_forwarding
                ? (EXE_mem_read & EXE_wb_en & exe_match)
                : ((EXE_wb_en & exe_match) | (MEM_wb_en & mem_match));

  // A pending load in EXE cannot be covered by forwarding, so the override is refused there.
  assign can_ignore = ignore_hazard & (~en_forwarding | ~EXE_mem_read);

  assign hz = raw_hz & ~can_ignore;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/bubble sequencer: SRAM wait FSM, hazard-output gating and a saturating stall counter.
// Memory freeze overrides data hazards; hazard outputs stay combinational.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_forwarding,
  input  logic                       ignore_hazard,
  input  logic [REG_ADDRESS_LEN-1:0] ID_src1,
  input  logic [REG_ADDRESS_LEN-1:0] ID_src2,
  input  logic                       ID_two_src,
  input  logic [REG_ADDRESS_LEN-1:0] EXE_dst,
  input  logic                       EXE_wb_en,
  input  logic                       EXE_mem_read,
  input  logic [REG_ADDRESS_LEN-1:0] MEM_dst,
  input  logic                       MEM_wb_en,
  input  logic                       MEM_mem_req,
  output logic                       freeze_front,
  output logic                       bubble_ID_EXE,
  output logic                       freeze_all,
  output logic                       sram_busy,
  output logic [15:0]                stall_cycles
);

  // WAIT lasts MEM_WAIT_CYCLES-2 cycles so that request cycle plus WAIT spans MEM_WAIT_CYCLES-1.
  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT_CYCLES - 2);

  sram_state_t state;
  logic [3:0]  wait_cnt;
  logic [15:0] stall_cnt;
  logic        hz;

  hazard_detect u_hazard_detect (
    .en_forwarding (en_forwarding),
    .ignore_hazard (ignore_hazard),
    .ID_src1       (ID_src1),
    .ID_src2       (ID_src2),
    .ID_two_src    (ID_two_src),
    .EXE_dst       (EXE_dst),
    .EXE_wb_en     (EXE_wb_en),
    .EXE_mem_read  (EXE_mem_read),
    .MEM_dst       (MEM_dst),
    .MEM_wb_en     (MEM_wb_en),
    .hz            (hz)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= SRAM_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        SRAM_IDLE: begin
          if (MEM_mem_req) begin
            if (MEM_WAIT_CYCLES == 2) begin
              state <= SRAM_DONE;
            end else begin
              state    <= SRAM_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        SRAM_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) state <= SRAM_DONE;
        end
        SRAM_DONE: state <= SRAM_IDLE;
        default:   state <= SRAM_IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is held so an in-flight access is aborted at once.
  assign freeze_all    = rst & (((state == SRAM_IDLE) & MEM_mem_req) | (state == SRAM_WAIT));
  assign sram_busy     = rst & (state == SRAM_WAIT);
  assign freeze_front  = rst & hz & ~freeze_all;
  assign bubble_ID_EXE = rst & hz & ~freeze_all;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if ((freeze_front | freeze_all) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios, random traffic and
// counter saturation, compared every cycle against an access-age based reference model.
module tb_pipeline_stall_ctrl;
  import pipeline_stall_ctrl_pkg::*;

  localparam int N  = 6;
  localparam int RL = REG_ADDRESS_LEN;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en_forwarding = 1'b0;
  logic          ignore_hazard = 1'b0;
  logic [RL-1:0] ID_src1 = '0;
  logic [RL-1:0] ID_src2 = '0;
  logic          ID_two_src = 1'b0;
  logic [RL-1:0] EXE_dst = '0;
  logic          EXE_wb_en = 1'b0;
  logic          EXE_mem_read = 1'b0;
  logic [RL-1:0] MEM_dst = '0;
  logic          MEM_wb_en = 1'b0;
  logic          MEM_mem_req = 1'b0;
  logic          freeze_front;
  logic          bubble_ID_EXE;
  logic          freeze_all;
  logic          sram_busy;
  logic [15:0]   stall_cycles;

  pipeline_stall_ctrl #(.MEM_WAIT_CYCLES(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .en_forwarding (en_forwarding),
    .ignore_hazard (ignore_hazard),
    .ID_src1       (ID_src1),
    .ID_src2       (ID_src2),
    .ID_two_src    (ID_two_src),
    .EXE_dst       (EXE_dst),
    .EXE_wb_en     (EXE_wb_en),
    .EXE_mem_read  (EXE_mem_read),
    .MEM_dst       (MEM_dst),
    .MEM_wb_en     (MEM_wb_en),
    .MEM_mem_req   (MEM_mem_req),
    .freeze_front  (freeze_front),
    .bubble_ID_EXE (bubble_ID_EXE),
    .freeze_all    (freeze_all),
    .sram_busy     (sram_busy),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: age = cycles since the request cycle of the current access (-1 = no access).
  int age = -1;
  int exp_cnt = 0;

  function automatic logic m_hz();
    logic m_exe;
    logic m_mem;
    logic h;
    m_exe = (ID_src1 == EXE_dst) || (ID_two_src && (ID_src2 == EXE_dst));
    m_mem = (ID_src1 == MEM_dst) || (ID_two_src && (ID_src2 == MEM_dst));
    if (en_forwarding) h = EXE_mem_read && EXE_wb_en && m_exe;
    else               h = (EXE_wb_en && m_exe) || (MEM_wb_en && m_mem);
    if (ignore_hazard && (!en_forwarding || !EXE_mem_read)) h = 1'b0;
    return h;
  endfunction

  function automatic logic m_freeze_all();
    return rst && (((age < 0) && MEM_mem_req) || ((age >= 1) && (age <= N - 2)));
  endfunction

  function automatic logic m_busy();
    return rst && (age >= 1) && (age <= N - 2);
  endfunction

  function automatic logic m_front();
    return rst && m_hz() && !m_freeze_all();
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      age     <= -1;
      exp_cnt <= 0;
    end else begin
      if (age < 0) age <= MEM_mem_req ? 1 : -1;
      else         age <= (age >= N - 1) ? -1 : age + 1;
      if ((m_front() || m_freeze_all()) && exp_cnt < 65535) exp_cnt <= exp_cnt + 1;
    end
  end

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    cmp(name, act, exp);
  endtask

  always @(negedge clk) begin
    logic [15:0] ec;
    ec = 16'(exp_cnt);
    vectors++;
    cmp("freeze_all",    {15'd0, freeze_all},    {15'd0, m_freeze_all()});
    cmp("sram_busy",     {15'd0, sram_busy},     {15'd0, m_busy()});
    cmp("freeze_front",  {15'd0, freeze_front},  {15'd0, m_front()});
    cmp("bubble_ID_EXE", {15'd0, bubble_ID_EXE}, {15'd0, m_front()});
    cmp("stall_cycles",  stall_cycles,           ec);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    en_forwarding = 0; ignore_hazard = 0; ID_src1 = 0; ID_src2 = 0; ID_two_src = 0;
    EXE_dst = 0; EXE_wb_en = 0; EXE_mem_read = 0; MEM_dst = 0; MEM_wb_en = 0; MEM_mem_req = 0;
  endtask

  task automatic reset_pulse();
    rst = 0;
    tick();
    rst = 1;
    tick();
  endtask

  task automatic set_load_use();
    en_forwarding = 1; EXE_mem_read = 1; EXE_wb_en = 1; EXE_dst = 3;
    ID_two_src = 1; ID_src2 = 3; ID_src1 = 5;
  endtask

  int pat[7] = '{1, 1, 1, 1, 1, 0, 1};

  initial begin
    clear_inputs();
    rst = 0;
    repeat (3) tick();
    lit("reset_freeze_all", {15'd0, freeze_all}, 16'd0);
    lit("reset_stall", stall_cycles, 16'd0);
    rst = 1;
    tick();

    // Reset mid-WAIT
    MEM_mem_req = 1;
    tick();
    #1 lit("wait_busy", {15'd0, sram_busy}, 16'd1);
    tick();
    rst = 0;
    #1;
    lit("rstwait_freeze_all", {15'd0, freeze_all}, 16'd0);
    lit("rstwait_busy", {15'd0, sram_busy}, 16'd0);
    lit("rstwait_stall", stall_cycles, 16'd0);
    MEM_mem_req = 0;
    tick();
    rst = 1;
    tick();

    // RAW hazard without forwarding
    EXE_wb_en = 1; EXE_dst = 2; ID_src1 = 2;
    #1 lit("raw_exe_front", {15'd0, freeze_front}, 16'd1);
    lit("raw_exe_bubble", {15'd0, bubble_ID_EXE}, 16'd1);
    tick();
    EXE_wb_en = 0; MEM_wb_en = 1; MEM_dst = 2;
    #1 lit("raw_mem_front", {15'd0, freeze_front}, 16'd1);
    tick();
    ID_src1 = 1;
    #1 lit("raw_nomatch", {15'd0, freeze_front}, 16'd0);
    tick();

    // Forwarding load-use and ignore_hazard rules
    clear_inputs();
    set_load_use();
    #1 lit("loaduse_bubble", {15'd0, bubble_ID_EXE}, 16'd1);
    tick();
    ignore_hazard = 1;
    #1 lit("loaduse_ignore_refused", {15'd0, bubble_ID_EXE}, 16'd1);
    tick();
    EXE_mem_read = 0;
    #1 lit("fwd_ignore_nobubble", {15'd0, bubble_ID_EXE}, 16'd0);
    tick();
    clear_inputs();

    // SRAM access and back-to-back ops
    reset_pulse();
    MEM_mem_req = 1;
    for (int i = 0; i < 7; i++) begin
      #1 lit($sformatf("sram_pat%0d", i), {15'd0, freeze_all}, 16'(pat[i]));
      if (i == 6) lit("sram_stall5", stall_cycles, 16'd5);
      tick();
    end
    MEM_mem_req = 0;
    repeat (8) tick();

    // Load-use during WAIT: held until DONE
    clear_inputs();
    tick();
    MEM_mem_req = 1;
    set_load_use();
    for (int i = 0; i < 6; i++) begin
      #1 lit($sformatf("wait_bubble%0d", i), {15'd0, bubble_ID_EXE}, (i == 5) ? 16'd1 : 16'd0);
      tick();
    end
    clear_inputs();
    repeat (3) tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(199) != 0);
      en_forwarding = 1'($urandom_range(1));
      ignore_hazard = ($urandom_range(3) == 0);
      ID_src1       = RL'($urandom_range(3));
      ID_src2       = RL'($urandom_range(3));
      ID_two_src    = 1'($urandom_range(1));
      EXE_dst       = RL'($urandom_range(3));
      EXE_wb_en     = 1'($urandom_range(1));
      EXE_mem_read  = 1'($urandom_range(1));
      MEM_dst       = RL'($urandom_range(3));
      MEM_wb_en     = 1'($urandom_range(1));
      MEM_mem_req   = ($urandom_range(3) == 0);
      tick();
    end
    rst = 1;
    clear_inputs();
    tick();

    // Saturation
    reset_pulse();
    EXE_wb_en = 1; EXE_dst = 2; ID_src1 = 2;
    repeat (65600) tick();
    lit("sat_stall", stall_cycles, 16'hFFFF);
    lit("sat_front", {15'd0, freeze_front}, 16'd1);
    clear_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
